bsg_mesh_proc_injector: RTL

//  Client-side transmitter for one mesh node's processor (P) port. Accepts destination + payload

---
 rtl/bsg_mesh_inject_pkg.sv | 23 ++
 rtl/bsg_mesh_inject_fifo.sv | 47 ++++
 rtl/bsg_mesh_proc_injector.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bsg_mesh_inject_pkg.sv
// Shared types for the mesh processor-port injector: packet layout and FSM state encoding.
package bsg_mesh_inject_pkg;

    localparam int DefDataWidth = 4;
    localparam int DefXWidth    = 1;
    localparam int DefYWidth    = 1;

    // Field order is LSB first: dest_x sits at bit 0 and src_y at the top.
    typedef struct packed {
        logic [DefYWidth-1:0]    src_y;
        logic [DefXWidth-1:0]    src_x;
        logic [DefDataWidth-1:0] payload;
        logic [DefYWidth-1:0]    dest_y;
        logic [DefXWidth-1:0]    dest_x;
    } packet_t;

    typedef logic [1:0] state_t;

    localparam state_t STATE_RUN   = 2'd0;
    localparam state_t STATE_DRAIN = 2'd1;
    localparam state_t STATE_DONE  = 2'd2;

endpackage

// File: rtl/bsg_mesh_inject_fifo.sv
// Two-entry registered FIFO. A push is accepted while full when a pop happens in the same cycle.
module bsg_mesh_inject_fifo
    import bsg_mesh_inject_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] mem_q [2];
    logic               rdPtr_q;
    logic               wrPtr_q;
    logic [1:0]         count_q;
    logic               doPush;
    logic               doPop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign doPop   = pop_i & ~empty_o;
    assign doPush  = push_i & (~full_o | doPop);
    assign data_o  = mem_q[rdPtr_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (doPush) wrPtr_q <= ~wrPtr_q;
            if (doPop)  rdPtr_q <= ~rdPtr_q;
            count_q <= count_q + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    // Storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_mesh_proc_injector.sv
// Processor-port injector with credit flow control and flush/drain FSM.
// Define BSG_MESH_INJECT_STATS_EN to add the sent/stall statistics counters.
module bsg_mesh_proc_injector
    import bsg_mesh_inject_pkg::*;
#(
    parameter  int data_width_p   = 4,
    parameter  int x_cord_width_p = 1,
    parameter  int y_cord_width_p = 1,
    parameter  int credits_p      = 4,
    localparam int width_lp       = 2*(x_cord_width_p+y_cord_width_p)+data_width_p
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      v_i,
    output logic                      ready_o,
    input  logic [x_cord_width_p-1:0] dest_x_i,
    input  logic [y_cord_width_p-1:0] dest_y_i,
    input  logic [data_width_p-1:0]   payload_i,
    output logic                      link_v_o,
    output logic [width_lp-1:0]       link_data_o,
    input  logic                      link_yumi_i,
    input  logic                      credit_i,
    input  logic                      flush_i,
    output logic                      drained_o,
`ifdef BSG_MESH_INJECT_STATS_EN
    output logic [31:0]               sent_cnt_o,
    output logic [31:0]               stall_cnt_o,
`endif
    output logic                      error_o
);

    localparam int CreditWidth = $clog2(credits_p + 1);
    localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(credits_p);

    typedef struct packed {
        logic [y_cord_width_p-1:0] src_y;
        logic [x_cord_width_p-1:0] src_x;
        logic [data_width_p-1:0]   payload;
        logic [y_cord_width_p-1:0] dest_y;
        logic [x_cord_width_p-1:0] dest_x;
    } pkt_t;

    pkt_t                   pktIn;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [width_lp-1:0]    fifoHead;
    logic                   accept;
    logic                   pop;
    logic                   creditOverflow;
    state_t                 state_q, state_d;
    logic [CreditWidth-1:0] creditCnt_q, creditCnt_d;
    logic                   error_q, error_d;

    always_comb begin
        pktIn.src_y   = my_y_i;
        pktIn.src_x   = my_x_i;
        pktIn.payload = payload_i;
        pktIn.dest_y  = dest_y_i;
        pktIn.dest_x  = dest_x_i;
    end

    assign ready_o     = (state_q == STATE_RUN) & ~fifoFull & (creditCnt_q != '0);
    assign accept      = v_i & ready_o;
    assign pop         = link_yumi_i & ~fifoEmpty;
    assign link_v_o    = ~fifoEmpty;
    assign link_data_o = fifoHead;
    assign drained_o   = (state_q == STATE_DONE);
    assign error_o     = error_q;

    bsg_mesh_inject_fifo #(
        .width_p (width_lp)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (accept),
        .data_i    (pktIn),
        .pop_i     (pop),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .data_o    (fifoHead)
    );

    // A returned credit and a newly spent one cancel; a surplus return saturates and is flagged.
    always_comb begin
        creditCnt_d    = creditCnt_q;
        creditOverflow = 1'b0;
        if (accept && !credit_i) begin
            creditCnt_d = creditCnt_q - CreditWidth'(1);
        end else if (credit_i && !accept) begin
            if (creditCnt_q == CreditMax) creditOverflow = 1'b1;
            else                          creditCnt_d = creditCnt_q + CreditWidth'(1);
        end
        error_d = error_q | creditOverflow | (link_yumi_i & fifoEmpty);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_RUN:   if (flush_i) state_d = STATE_DRAIN;
            STATE_DRAIN: if (fifoEmpty && creditCnt_q == CreditMax) state_d = STATE_DONE;
            STATE_DONE:  state_d = flush_i ? STATE_DRAIN : STATE_RUN;
            default:     state_d = STATE_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= STATE_RUN;
            creditCnt_q <= CreditMax;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            creditCnt_q <= creditCnt_d;
            error_q     <= error_d;
        end
    end

`ifdef BSG_MESH_INJECT_STATS_EN
    logic [31:0] sentCnt_q;
    logic [31:0] stallCnt_q;

    assign sent_cnt_o  = sentCnt_q;
    assign stall_cnt_o = stallCnt_q;

    // Sent count wraps naturally; stall count holds at all-ones.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sentCnt_q  <= 32'd0;
            stallCnt_q <= 32'd0;
        end else begin
            if (pop) sentCnt_q <= sentCnt_q + 32'd1;
            if (v_i && !ready_o && stallCnt_q != 32'hFFFF_FFFF) stallCnt_q <= stallCnt_q + 32'd1;
        end
    end
`endif

endmodule
